// File: rtl/spi_flash_read_seq.sv
// Flash READ sequencer: drives the SPI byte engine through CS setup, opcode, address,
// optional dummy and data bytes. Define QUAD_READ_EN to enable the 0x6B quad fast read.
module spi_flash_read_seq #(
  parameter int ADDR_BYTES = 3,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_IDLE    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [8*ADDR_BYTES-1:0] cmd_addr_i,
  input  logic [15:0]             cmd_len_i,
  input  logic                    cmd_quad_i,
  input  logic                    cmd_abort_i,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic [7:0]              rd_data_o,
  output logic                    busy_o,
  output logic                    spi_cs_n_o,
  output logic [3:0]              spi_oe_o,
  output logic                    eng_strobe_o,
  output logic [7:0]              eng_tx_o,
  output logic [2:0]              eng_mode_o,
  input  logic [7:0]              eng_rx_i,
  input  logic                    eng_idle_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_CMD, S_ADDR,
`ifdef QUAD_READ_EN
    S_DUMMY,
`endif
    S_DATA, S_WAIT_RD, S_HOLD, S_GAP
  } state_e;

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);
  localparam logic [2:0]  ADDR_LAST  = 3'(ADDR_BYTES - 1);

  state_e                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
  logic [15:0]             len_q, len_d;
  logic                    abort_q, abort_d;
  logic                    inflight_q, inflight_d;
  logic                    settle_q, settle_d;
  logic [2:0]              idx_q, idx_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [7:0]              rd_data_q, rd_data_d;
  logic                    quad_active;
  logic                    byte_state;
  logic                    issue;
  logic                    byte_done;

`ifdef QUAD_READ_EN
  logic quad_q, quad_d;
  assign quad_active = quad_q;
`else
  logic unused_quad;
  assign unused_quad = cmd_quad_i;
  assign quad_active = 1'b0;
`endif

  assign byte_state = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA)
`ifdef QUAD_READ_EN
                      || (state_q == S_DUMMY)
`endif
                      ;
  // A new byte starts only when none is in flight, no abort is pending and data remains.
  assign issue     = !reset && byte_state && !inflight_q && !abort_q &&
                     !((state_q == S_DATA) && (len_q == '0));
  // eng_idle is stale in the strobe cycle and the one after, so it is masked by settle_q.
  assign byte_done = inflight_q && !settle_q && eng_idle_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      abort_q    <= 1'b0;
      inflight_q <= 1'b0;
      settle_q   <= 1'b0;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef QUAD_READ_EN
      quad_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      abort_q    <= abort_d;
      inflight_q <= inflight_d;
      settle_q   <= settle_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
`ifdef QUAD_READ_EN
      quad_q     <= quad_d;
`endif
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    abort_d    = abort_q || ((state_q != S_IDLE) && cmd_abort_i);
    inflight_d = (inflight_q && !byte_done) || issue;
    settle_d   = issue;
    idx_d      = idx_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
`ifdef QUAD_READ_EN
    quad_d     = quad_q;
`endif
    case (state_q)
      S_IDLE: if (cmd_valid_i) begin
        addr_d  = cmd_addr_i;
        len_d   = cmd_len_i;
        abort_d = 1'b0;
        cnt_d   = '0;
`ifdef QUAD_READ_EN
        quad_d  = cmd_quad_i;
`endif
        state_d = S_SETUP;
      end
      S_SETUP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (!inflight_q && abort_q) state_d = S_HOLD;
        else if (byte_done) begin
          idx_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!inflight_q && abort_q) state_d = S_HOLD;
        else if (byte_done) begin
          addr_d = addr_q << 8;
          idx_d  = idx_q + 3'd1;
          if (idx_q == ADDR_LAST) begin
`ifdef QUAD_READ_EN
            state_d = quad_q ? S_DUMMY : S_DATA;
`else
            state_d = S_DATA;
`endif
          end
        end
      end
`ifdef QUAD_READ_EN
      S_DUMMY: begin
        if (!inflight_q && abort_q) state_d = S_HOLD;
        else if (byte_done) state_d = S_DATA;
      end
`endif
      S_DATA: begin
        if (!inflight_q && (abort_q || (len_q == '0))) state_d = S_HOLD;
        else if (byte_done) begin
          rd_data_d  = eng_rx_i;
          rd_valid_d = 1'b1;
          len_d      = len_q - 16'd1;
          state_d    = S_WAIT_RD;
        end
      end
      S_WAIT_RD: if (rd_ready_i) begin
        rd_valid_d = 1'b0;
        state_d    = S_DATA;
      end
      S_HOLD: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == IDLE_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o  = (state_q == S_IDLE) && !reset;
    busy_o       = (state_q != S_IDLE);
    spi_cs_n_o   = (state_q == S_IDLE) || (state_q == S_GAP);
    rd_valid_o   = rd_valid_q;
    rd_data_o    = rd_data_q;
    eng_strobe_o = issue;
    eng_tx_o     = 8'h00;
    eng_mode_o   = 3'd1;
    spi_oe_o     = 4'b0001;
    if (issue) begin
      case (state_q)
        S_CMD:   eng_tx_o = quad_active ? 8'h6B : 8'h03;
        S_ADDR:  eng_tx_o = addr_q[8*ADDR_BYTES-1 -: 8];
        S_DATA:  eng_tx_o = 8'hFF;
        default: eng_tx_o = 8'h00;
      endcase
      if ((state_q == S_DATA) && quad_active) eng_mode_o = 3'd4;
    end
    // Pads turn around with the first quad data strobe and back once data ends.
    if (quad_active && ((state_q == S_WAIT_RD) ||
                        ((state_q == S_DATA) && (inflight_q || issue))))
      spi_oe_o = 4'b0000;
  end

endmodule
